// File: rtl/ipbus_reg_slave_if.sv
// IPbus transaction signals between a bus master and a register-file slave.
interface ipbus_reg_slave_if;
  localparam int unsigned DW = 32;

  logic [DW-1:0] ipb_addr;
  logic [DW-1:0] ipb_wdata;
  logic          ipb_strobe;
  logic          ipb_write;
  logic [DW-1:0] ipb_rdata;
  logic          ipb_ack;
  logic          ipb_err;

  modport master (
    output ipb_addr, ipb_wdata, ipb_strobe, ipb_write,
    input  ipb_rdata, ipb_ack, ipb_err
  );

  modport slave (
    input  ipb_addr, ipb_wdata, ipb_strobe, ipb_write,
    output ipb_rdata, ipb_ack, ipb_err
  );
endinterface

// File: rtl/ipbus_reg_slave.sv
// IPbus register-file slave: N_REGS words (word 0 a read-only ID), programmable
// wait states before a one-cycle ack/err, and a wrapping count of successful writes.
module ipbus_reg_slave #(
  parameter int unsigned N_REGS      = 8,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hC0FF_EE01
) (
  input  logic                   CLK,
  input  logic                   RST,
  ipbus_reg_slave_if.slave       ipb,
  output logic [32*N_REGS-1:0]   reg_q,
  output logic [15:0]            write_count
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned WC_W  = 16;
  localparam int unsigned IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_e;

  typedef struct packed {
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          write;
  } req_t;

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [WC_W-1:0]   write_count_q, write_count_d;
  logic [DW-1:0]     regs_q [N_REGS];
  logic [DW-1:0]     regs_d [N_REGS];

  logic [DW-1:0]     offset;
  logic [IDX_W-1:0]  idx;
  logic              valid;
  logic              is_id;

  // Decode uses the captured address; below-base addresses wrap to huge offsets.
  assign offset = req_q.addr - ADDR_BASE;
  assign valid  = offset < DW'(N_REGS);
  assign is_id  = offset == '0;
  assign idx    = offset[IDX_W-1:0];

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    cnt_d         = cnt_q;
    ack_d         = 1'b0;
    err_d         = 1'b0;
    rdata_d       = '0;
    write_count_d = write_count_q;
    regs_d        = regs_q;

    case (state_q)
      S_IDLE: begin
        if (ipb.ipb_strobe) begin
          req_d   = '{addr: ipb.ipb_addr, wdata: ipb.ipb_wdata, write: ipb.ipb_write};
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (!ipb.ipb_strobe) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_HOLD;
        if (!valid || (req_q.write && is_id)) begin
          err_d = 1'b1;
        end else if (req_q.write) begin
          ack_d         = 1'b1;
          regs_d[idx]   = req_q.wdata;
          write_count_d = write_count_q + WC_W'(1);
        end else begin
          ack_d   = 1'b1;
          rdata_d = is_id ? ID_VALUE : regs_q[idx];
        end
      end
      S_HOLD: begin
        // A strobe still held after the response must not start a new access.
        if (!ipb.ipb_strobe) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      req_q         <= '0;
      cnt_q         <= '0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      write_count_q <= '0;
      for (int i = 0; i < int'(N_REGS); i++) regs_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      cnt_q         <= cnt_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      write_count_q <= write_count_d;
      regs_q        <= regs_d;
    end
  end

  assign ipb.ipb_ack   = ack_q;
  assign ipb.ipb_err   = err_q;
  assign ipb.ipb_rdata = rdata_q;
  assign write_count   = write_count_q;

  // Word 0 is the constant ID, never a storage location.
  assign reg_q[DW-1:0] = ID_VALUE;
  for (genvar g = 1; g < N_REGS; g++) begin : g_flat
    assign reg_q[DW*g +: DW] = regs_q[g];
  end

endmodule
